btn_event_decoder: RTL

Converts the debounced, registered button levels from the button-conditioning stage (btn_salud, btn_hambre, btn_reset, btn_test) into the single-cycle game events and the test-mode flag consumed by the pet state machine.
- Short presses of heal and feed produce one-cycle pulses.
- Reset and test require a timed long press.
- A short test press while in test mode advances the test step.

Sits directly downstream of the button-conditioning stage and upstream of the game FSM.

---
 rtl/btn_event_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/btn_event_decoder.sv
// ============================================================================
//  Module   : btn_event_decoder
//  Purpose  : Turns debounced button levels into one-cycle game events and
//             the test-mode flag. Optional auto-repeat on heal/feed is built
//             only when BTN_REPEAT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_event_decoder #(
  parameter int TICKS_PER_MS = 50000,
  parameter int HOLD_RST_MS  = 5000,
  parameter int HOLD_TST_MS  = 3000,
  parameter int REPEAT_MS    = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_salud,
  input  logic btn_hambre,
  input  logic btn_reset,
  input  logic btn_test,
  output logic ev_curar,
  output logic ev_alimentar,
  output logic ev_reset_juego,
  output logic ev_test_step,
  output logic test_mode
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [15:0] HOLD_R = 16'(HOLD_RST_MS);
  localparam logic [15:0] HOLD_T = 16'(HOLD_TST_MS);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_COUNT = 2'd1, R_WAIT = 2'd2} r_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_COUNT = 2'd1, T_WAIT = 2'd2} t_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Bit order of the button vectors: {test, reset, hambre, salud}
  logic [3:0] smp, prv;
  logic [3:0] press, rel;
  logic [TW-1:0] tick_cnt;
  logic tick;

  r_state_t r_state, r_state_nx;
  t_state_t t_state, t_state_nx;
  logic [15:0] r_cnt, r_cnt_nx, t_cnt, t_cnt_nx;
  logic lockout, lockout_nx, mode_nx;
  logic rst_fire, tst_fire, step, block;
  logic curar_nx, alimentar_nx, step_nx;
  logic [1:0] rep_hit;

  assign press = smp & ~prv;
  assign rel   = ~smp & prv;
  assign tick  = (tick_cnt == TW'(TICKS_PER_MS - 1));

  always_comb begin
    r_state_nx = r_state;
    r_cnt_nx   = r_cnt;
    rst_fire   = 1'b0;
    unique case (r_state)
      R_IDLE: if (press[2]) begin
        r_state_nx = R_COUNT;
        r_cnt_nx   = '0;
      end
      R_COUNT: begin
        if (rel[2]) begin
          r_state_nx = R_IDLE;
        end else if (tick) begin
          r_cnt_nx = sat_inc(r_cnt);
          if (r_cnt_nx >= HOLD_R) begin
            rst_fire   = 1'b1;
            r_state_nx = R_WAIT;
          end
        end
      end
      R_WAIT:  if (!smp[2]) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase

    t_state_nx = t_state;
    t_cnt_nx   = t_cnt;
    tst_fire   = 1'b0;
    step       = 1'b0;
    if (lockout) begin
      t_state_nx = T_IDLE;
    end else begin
      unique case (t_state)
        T_IDLE: if (press[3]) begin
          t_state_nx = T_COUNT;
          t_cnt_nx   = '0;
        end
        T_COUNT: begin
          if (rel[3]) begin
            t_state_nx = T_IDLE;
            step       = test_mode;
          end else if (tick) begin
            t_cnt_nx = sat_inc(t_cnt);
            if (t_cnt_nx >= HOLD_T) begin
              tst_fire   = 1'b1;
              t_state_nx = T_WAIT;
            end
          end
        end
        T_WAIT:  if (!smp[3]) t_state_nx = T_IDLE;
        default: t_state_nx = T_IDLE;
      endcase
    end

    // A game reset overrides whatever the test FSM decided this cycle
    mode_nx = test_mode;
    if (rst_fire) begin
      mode_nx    = 1'b0;
      t_state_nx = T_IDLE;
    end else if (tst_fire) begin
      mode_nx = ~test_mode;
    end

    lockout_nx = lockout;
    if (rst_fire)        lockout_nx = 1'b1;
    else if (smp == '0)  lockout_nx = 1'b0;

    block        = lockout | rst_fire;
    curar_nx     = (press[0] | rep_hit[0]) & ~block;
    alimentar_nx = (press[1] | rep_hit[1]) & ~block;
    step_nx      = step & ~block;
  end

`ifdef BTN_REPEAT_EN
  localparam logic [15:0] REP = 16'(REPEAT_MS);
  logic [1:0][15:0] rp_cnt, rp_cnt_nx;

  always_comb begin
    rp_cnt_nx = rp_cnt;
    rep_hit   = '0;
    for (int i = 0; i < 2; i++) begin
      if (press[i]) begin
        rp_cnt_nx[i] = '0;
      end else if (smp[i] && !block && tick) begin
        rp_cnt_nx[i] = sat_inc(rp_cnt[i]);
        if (rp_cnt_nx[i] >= REP) begin
          rep_hit[i]   = 1'b1;
          rp_cnt_nx[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rp_cnt <= '0;
    else     rp_cnt <= rp_cnt_nx;
  end
`else
  // REPEAT_MS only matters for the auto-repeat build
  assign rep_hit = (REPEAT_MS < 0) ? 2'b11 : 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // Previous samples start high so a button held through reset is not a press
      smp            <= '1;
      prv            <= '1;
      tick_cnt       <= '0;
      r_state        <= R_IDLE;
      t_state        <= T_IDLE;
      r_cnt          <= '0;
      t_cnt          <= '0;
      lockout        <= 1'b0;
      test_mode      <= 1'b0;
      ev_curar       <= 1'b0;
      ev_alimentar   <= 1'b0;
      ev_reset_juego <= 1'b0;
      ev_test_step   <= 1'b0;
    end else begin
      smp            <= {btn_test, btn_reset, btn_hambre, btn_salud};
      prv            <= smp;
      tick_cnt       <= tick ? '0 : tick_cnt + TW'(1);
      r_state        <= r_state_nx;
      t_state        <= t_state_nx;
      r_cnt          <= r_cnt_nx;
      t_cnt          <= t_cnt_nx;
      lockout        <= lockout_nx;
      test_mode      <= mode_nx;
      ev_curar       <= curar_nx;
      ev_alimentar   <= alimentar_nx;
      ev_reset_juego <= rst_fire;
      ev_test_step   <= step_nx;
    end
  end

endmodule

`default_nettype wire
